stream_avg_accum: RTL

//  Parametrised sequential averager and successor to the fixed 8-input add/REG chain.

---
 rtl/stream_avg_accum.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/stream_avg_accum.sv
// ---------------------------------------------------------------------------
// stream_avg_accum
//
// Sequential averager. A run of `num` unsigned samples is accepted over a
// valid/ready input stream and summed into a wide accumulator. The sum is then
// divided by `num` with a bit-serial restoring divider. The result is offered
// on a valid/ready output as avg = floor(sum/num) together with the exact sum.
//
// Ports
//   Clk        rising-edge clock
//   Rst        asynchronous, active-low reset
//   start      begin a run (sampled only while idle)
//   num        sample count for the run, latched when start is accepted
//   busy       high in every state except idle
//   in_valid   sample valid
//   in_ready   high only while accumulating
//   in_data    unsigned sample
//   out_valid  result valid
//   out_ready  consumer accepts result
//   avg        floor(sum/num)
//   sum        exact sum of the run
//   dz         the run had num == 0 (no division performed)
// ---------------------------------------------------------------------------
module stream_avg_accum #(
   parameter int DATAWIDTH = 16,
   parameter int CNTW      = 8
) (
   input  logic                      Clk,
   input  logic                      Rst,
   input  logic                      start,
   input  logic [CNTW-1:0]           num,
   output logic                      busy,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [DATAWIDTH-1:0]      in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [DATAWIDTH-1:0]      avg,
   output logic [DATAWIDTH+CNTW-1:0] sum,
   output logic                      dz
);

   // A run of at most 2^CNTW-1 samples of DATAWIDTH bits always fits here.
   localparam int ACCW  = DATAWIDTH + CNTW;
   localparam int STEPW = $clog2(ACCW + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_DIVIDE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [CNTW-1:0]   num_q;
   logic [CNTW-1:0]   cnt_q;
   // Holds the running sum while accumulating; during division it doubles as
   // the dividend/quotient shift register (dividend bits leave at the top,
   // quotient bits enter at the bottom).
   logic [ACCW-1:0]   acc_q;
   logic [CNTW-1:0]   rem_q;
   logic [STEPW-1:0]  step_q;
   logic [DATAWIDTH-1:0] avg_q;
   logic [ACCW-1:0]   sum_q;
   logic              dz_q;

   logic              xfer;
   logic              last_xfer;
   logic              last_step;
   logic [CNTW:0]     rem_sh;
   logic [CNTW:0]     rem_diff;
   logic              q_bit;
   logic [CNTW-1:0]   rem_nx;
   logic [ACCW-1:0]   q_nx;

   assign xfer      = in_valid && (state_q == S_ACCUM);
   assign last_xfer = xfer && (cnt_q == num_q - CNTW'(1));
   // Divide phase: step 0 captures the sum and clears the remainder, steps
   // 1..ACCW each produce one quotient bit, MSB first.
   assign last_step = (step_q == STEPW'(ACCW));

   // One restoring-division step. The remainder is always < num_q, so after
   // the shift it needs one extra bit; the borrow of the trial subtraction
   // says whether the divisor fits.
   always_comb begin
      rem_sh   = {rem_q, acc_q[ACCW-1]};
      rem_diff = rem_sh - {1'b0, num_q};
      q_bit    = ~rem_diff[CNTW];
      rem_nx   = q_bit ? rem_diff[CNTW-1:0] : rem_sh[CNTW-1:0];
      q_nx     = {acc_q[ACCW-2:0], q_bit};
   end

   // NOTE: every signal written in an always_comb gets a default first, so no
   // path through the case statement can leave it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      busy      = 1'b1;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_d = (num == '0) ? S_DONE : S_ACCUM;
         end
         S_ACCUM: begin
            in_ready = 1'b1;
            if (last_xfer) state_d = S_DIVIDE;
         end
         S_DIVIDE: begin
            if (last_step) state_d = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: all state is updated with non-blocking assignments so every
   // register samples the values from before the edge, independent of the
   // order of statements in this block.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q <= S_IDLE;
         num_q   <= '0;
         cnt_q   <= '0;
         acc_q   <= '0;
         rem_q   <= '0;
         step_q  <= '0;
         avg_q   <= '0;
         sum_q   <= '0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  num_q  <= num;
                  cnt_q  <= '0;
                  acc_q  <= '0;
                  step_q <= '0;
                  avg_q  <= '0;
                  sum_q  <= '0;
                  dz_q   <= (num == '0);
               end
            end
            S_ACCUM: begin
               if (xfer) begin
                  acc_q <= acc_q + ACCW'(in_data);
                  cnt_q <= cnt_q + CNTW'(1);
               end
            end
            S_DIVIDE: begin
               step_q <= step_q + STEPW'(1);
               if (step_q == '0) begin
                  sum_q <= acc_q;
                  rem_q <= '0;
               end else begin
                  acc_q <= q_nx;
                  rem_q <= rem_nx;
                  // The quotient never exceeds the largest sample, so its
                  // low DATAWIDTH bits are the whole result.
                  if (last_step) avg_q <= q_nx[DATAWIDTH-1:0];
               end
            end
            S_DONE: begin
               // Results are held; nothing changes until the next run.
            end
            default: begin
            end
         endcase
      end
   end

   assign avg = avg_q;
   assign sum = sum_q;
   assign dz  = dz_q;

endmodule
